// File: rtl/rtype_exec_ctrl.sv
// Multi-cycle R-type execution controller: owns the register file, decodes one
// instruction at a time, drives the external ALU and writes its result back.
module rtype_exec_ctrl #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_valid,
   output logic              inst_ready,
   input  logic [31:0]       inst,
   output logic [2:0]        ALU_OP,
   output logic [DATA_W-1:0] ALU_A,
   output logic [DATA_W-1:0] ALU_B,
   input  logic [DATA_W-1:0] ALU_F,
   input  logic              ALU_ZF,
   input  logic              ALU_OF,
   output logic              done,
   output logic              illegal,
   output logic              ZF,
   output logic              OF,
   input  logic              dbg_we,
   input  logic [REG_AW-1:0] dbg_waddr,
   input  logic [DATA_W-1:0] dbg_wdata,
   input  logic [REG_AW-1:0] dbg_raddr,
   output logic [DATA_W-1:0] dbg_rdata
);

   localparam int unsigned NREGS = 1 << REG_AW;

   typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] regs [NREGS];
   logic [31:0]       inst_q;
   logic [DATA_W-1:0] f_q;
   logic              zf_q, of_q, illegal_q;
   logic [2:0]        dec_op;
   logic              dec_illegal;
   logic [REG_AW-1:0] rs, rt, rd;
   logic              unused_shamt;

   assign rs = inst_q[21 +: REG_AW];
   assign rt = inst_q[16 +: REG_AW];
   assign rd = inst_q[11 +: REG_AW];
   assign unused_shamt = ^inst_q[10:6];

   // R0 is never written and is cleared on reset, so a plain read returns 0.
   assign dbg_rdata = regs[dbg_raddr];

   always_comb begin
      dec_op      = 3'b000;
      dec_illegal = 1'b0;
      if (inst_q[31:26] != 6'b000000) begin
         dec_illegal = 1'b1;
      end else begin
         unique case (inst_q[5:0])
            6'b100100: dec_op = 3'b000;
            6'b100101: dec_op = 3'b001;
            6'b100110: dec_op = 3'b010;
            6'b100111: dec_op = 3'b011;
            6'b100000: dec_op = 3'b100;
            6'b100010: dec_op = 3'b101;
            6'b101010: dec_op = 3'b110;
            6'b000100: dec_op = 3'b111;
            default:   dec_illegal = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Illegal instructions still walk DECODE/EXEC/WB so retire timing matches.
   always_comb begin
      state_nxt  = state;
      inst_ready = 1'b0;
      done       = 1'b0;
      illegal    = 1'b0;
      unique case (state)
         IDLE: begin
            inst_ready = 1'b1;
            if (inst_valid) state_nxt = DECODE;
         end
         DECODE: state_nxt = EXEC;
         EXEC:   state_nxt = WB;
         WB: begin
            done      = 1'b1;
            illegal   = illegal_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs      <= '{default: '0};
         inst_q    <= '0;
         ALU_OP    <= '0;
         ALU_A     <= '0;
         ALU_B     <= '0;
         f_q       <= '0;
         zf_q      <= 1'b0;
         of_q      <= 1'b0;
         illegal_q <= 1'b0;
         ZF        <= 1'b0;
         OF        <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (inst_valid) inst_q <= inst;
               if (dbg_we && (dbg_waddr != '0)) regs[dbg_waddr] <= dbg_wdata;
            end
            DECODE: begin
               illegal_q <= dec_illegal;
               if (!dec_illegal) begin
                  ALU_OP <= dec_op;
                  ALU_A  <= regs[rs];
                  ALU_B  <= regs[rt];
               end
            end
            EXEC: begin
               f_q  <= ALU_F;
               zf_q <= ALU_ZF;
               of_q <= ALU_OF;
            end
            WB: begin
               if (!illegal_q) begin
                  if (rd != '0) regs[rd] <= f_q;
                  ZF <= zf_q;
                  OF <= of_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rtype_exec_ctrl.sv
// Directed bench for rtype_exec_ctrl with a behavioural ALU attached.
module tb_rtype_exec_ctrl;

   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110;
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_SLLV = 6'b000100;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [2:0]  alu_op;
   logic [31:0] alu_a, alu_b, alu_f;
   logic        alu_zf, alu_of;
   logic        done, illegal, zf, of;
   logic        dbg_we;
   logic [4:0]  dbg_waddr, dbg_raddr;
   logic [31:0] dbg_wdata, dbg_rdata;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   rtype_exec_ctrl #(.DATA_W(32), .REG_AW(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .inst       (inst),
      .ALU_OP     (alu_op),
      .ALU_A      (alu_a),
      .ALU_B      (alu_b),
      .ALU_F      (alu_f),
      .ALU_ZF     (alu_zf),
      .ALU_OF     (alu_of),
      .done       (done),
      .illegal    (illegal),
      .ZF         (zf),
      .OF         (of),
      .dbg_we     (dbg_we),
      .dbg_waddr  (dbg_waddr),
      .dbg_wdata  (dbg_wdata),
      .dbg_raddr  (dbg_raddr),
      .dbg_rdata  (dbg_rdata)
   );

   logic [31:0] sum, diff;
   always_comb begin
      sum    = alu_a + alu_b;
      diff   = alu_a - alu_b;
      alu_f  = '0;
      alu_of = 1'b0;
      case (alu_op)
         3'b000: alu_f = alu_a & alu_b;
         3'b001: alu_f = alu_a | alu_b;
         3'b010: alu_f = alu_a ^ alu_b;
         3'b011: alu_f = ~(alu_a | alu_b);
         3'b100: begin
            alu_f  = sum;
            alu_of = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
         end
         3'b101: begin
            alu_f  = diff;
            alu_of = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
         end
         3'b110: alu_f = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
         default: alu_f = alu_b << alu_a[4:0];
      endcase
      alu_zf = (alu_f == '0);
   end

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, 5'b00000, fn};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
      dbg_we = 1'b1; dbg_waddr = a; dbg_wdata = d;
      @(posedge clk); #1;
      dbg_we = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] e);
      @(negedge clk);
      dbg_raddr = a;
      #1;
      check(tag, dbg_rdata, e);
   endtask

   // dmode: 0 none, 1 debug write concurrent with accept, 2 debug write during EXEC
   task automatic run_inst(input string tag, input logic [31:0] instr, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic ill,
                           input int dmode, input logic [4:0] daddr, input logic [31:0] ddata);
      check({tag, "_ready_idle"}, inst_ready, 1);
      inst = instr; inst_valid = 1'b1;
      if (dmode == 1) begin dbg_we = 1'b1; dbg_waddr = daddr; dbg_wdata = ddata; end
      @(posedge clk); #1;
      inst_valid = 1'b0; dbg_we = 1'b0; inst = 32'hFFFF_FFFF;
      check({tag, "_ready_decode"}, inst_ready, 0);
      check({tag, "_done_decode"}, done, 0);
      @(posedge clk); #1;
      if (!ill) begin
         check({tag, "_op"}, alu_op, op);
         check({tag, "_a"}, alu_a, a);
         check({tag, "_b"}, alu_b, b);
      end
      check({tag, "_done_exec"}, done, 0);
      if (dmode == 2) begin dbg_we = 1'b1; dbg_waddr = daddr; dbg_wdata = ddata; end
      @(posedge clk); #1;
      dbg_we = 1'b0;
      check({tag, "_done_wb"}, done, 1);
      check({tag, "_illegal_wb"}, illegal, ill);
      @(posedge clk); #1;
      check({tag, "_done_after"}, done, 0);
      check({tag, "_illegal_after"}, illegal, 0);
      check({tag, "_ready_after"}, inst_ready, 1);
   endtask

   initial begin
      rst = 1'b1; inst_valid = 1'b0; inst = '0;
      dbg_we = 1'b0; dbg_waddr = '0; dbg_wdata = '0; dbg_raddr = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_ready", inst_ready, 1);
      check("rst_done", done, 0);
      check("rst_illegal", illegal, 0);
      check("rst_zf", zf, 0);
      check("rst_of", of, 0);
      check("rst_aluop", alu_op, 0);
      check("rst_alua", alu_a, 0);
      check("rst_alub", alu_b, 0);

      // ADD: -1 + -1
      dbg_write(5'd1, 32'hFFFF_FFFF);
      dbg_write(5'd2, 32'hFFFF_FFFF);
      run_inst("add", rtype(5'd1, 5'd2, 5'd3, F_ADD), 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, '0, '0);
      rd_check("add_r3", 5'd3, 32'hFFFF_FFFE);
      check("add_zf", zf, 0);
      check("add_of", of, 0);

      // SUB
      dbg_write(5'd1, 32'h0FFF_FFFF);
      run_inst("sub", rtype(5'd1, 5'd2, 5'd4, F_SUB), 3'b101, 32'h0FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, '0, '0);
      rd_check("sub_r4", 5'd4, 32'h1000_0000);
      check("sub_zf", zf, 0);
      check("sub_of", of, 0);
      check("sub_alua_hold", alu_a, 32'h0FFF_FFFF);

      // Signed overflow: result still written, OF latched
      dbg_write(5'd1, 32'h7FFF_FFFF);
      dbg_write(5'd2, 32'h0000_0001);
      run_inst("ovf", rtype(5'd1, 5'd2, 5'd8, F_ADD), 3'b100, 32'h7FFF_FFFF, 32'h1, 1'b0, 0, '0, '0);
      rd_check("ovf_r8", 5'd8, 32'h8000_0000);
      check("ovf_of", of, 1);
      check("ovf_zf", zf, 0);

      // Illegal opcode, then illegal funct
      run_inst("ill_op", {6'b000010, 5'd1, 5'd2, 5'd3, 5'd0, F_ADD}, 3'b000, '0, '0, 1'b1, 0, '0, '0);
      rd_check("ill_op_r3", 5'd3, 32'hFFFF_FFFE);
      check("ill_op_of", of, 1);
      check("ill_op_zf", zf, 0);
      check("ill_op_aluop_hold", alu_op, 3'b100);
      run_inst("ill_fn", rtype(5'd1, 5'd2, 5'd3, 6'b111111), 3'b000, '0, '0, 1'b1, 0, '0, '0);
      rd_check("ill_fn_r3", 5'd3, 32'hFFFF_FFFE);
      check("ill_fn_of", of, 1);

      // XOR to R0: dropped write, flags still update
      dbg_write(5'd1, 32'h1234_5678);
      dbg_write(5'd2, 32'h1234_5678);
      run_inst("xor0", rtype(5'd1, 5'd2, 5'd0, F_XOR), 3'b010, 32'h1234_5678, 32'h1234_5678, 1'b0, 0, '0, '0);
      rd_check("xor0_r0", 5'd0, 32'h0);
      check("xor0_zf", zf, 1);
      check("xor0_of", of, 0);

      // SLT signed, then SLLV with a debug write concurrent with accept
      dbg_write(5'd1, 32'hFFFF_FFFF);
      dbg_write(5'd2, 32'h0000_0001);
      run_inst("slt", rtype(5'd1, 5'd2, 5'd9, F_SLT), 3'b110, 32'hFFFF_FFFF, 32'h1, 1'b0, 0, '0, '0);
      rd_check("slt_r9", 5'd9, 32'h1);
      dbg_write(5'd2, 32'h0000_0003);
      run_inst("sllv", rtype(5'd1, 5'd2, 5'd10, F_SLLV), 3'b111, 32'h4, 32'h3, 1'b0, 1, 5'd1, 32'h4);
      rd_check("sllv_r10", 5'd10, 32'h30);

      // OR quick check
      run_inst("or", rtype(5'd9, 5'd10, 5'd12, F_OR), 3'b001, 32'h1, 32'h30, 1'b0, 0, '0, '0);
      rd_check("or_r12", 5'd12, 32'h31);

      // Dependent chain, second accepted right after the first retires
      dbg_write(5'd1, 32'h0000_0003);
      dbg_write(5'd2, 32'h0000_0010);
      run_inst("dep_add", rtype(5'd1, 5'd2, 5'd5, F_ADD), 3'b100, 32'h3, 32'h10, 1'b0, 0, '0, '0);
      run_inst("dep_and", rtype(5'd5, 5'd1, 5'd6, F_AND), 3'b000, 32'h13, 32'h3, 1'b0, 2, 5'd1, 32'hDEAD_BEEF);
      rd_check("dep_r6", 5'd6, 32'h3);
      rd_check("dep_r1_kept", 5'd1, 32'h3);
      rd_check("dep_r5", 5'd5, 32'h13);

      // SUB overflow sets OF before the reset test
      dbg_write(5'd1, 32'h8000_0000);
      dbg_write(5'd2, 32'h0000_0001);
      run_inst("subovf", rtype(5'd1, 5'd2, 5'd11, F_SUB), 3'b101, 32'h8000_0000, 32'h1, 1'b0, 0, '0, '0);
      rd_check("subovf_r11", 5'd11, 32'h7FFF_FFFF);
      check("subovf_of", of, 1);

      // Reset in EXEC discards the instruction and clears everything
      dbg_write(5'd1, 32'h0000_0001);
      dbg_write(5'd2, 32'h0000_0002);
      inst = rtype(5'd1, 5'd2, 5'd7, F_ADD); inst_valid = 1'b1;
      @(posedge clk); #1;
      inst_valid = 1'b0;
      @(posedge clk); #1;
      check("rstx_op_exec", alu_op, 3'b100);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rstx_done", done, 0);
      check("rstx_ready", inst_ready, 1);
      check("rstx_aluop", alu_op, 0);
      check("rstx_alua", alu_a, 0);
      check("rstx_of", of, 0);
      @(posedge clk); #1;
      check("rstx_done2", done, 0);
      check("rstx_illegal2", illegal, 0);
      rd_check("rstx_r7", 5'd7, 32'h0);
      rd_check("rstx_r1", 5'd1, 32'h0);
      rd_check("rstx_r11", 5'd11, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
